uart_byte_fifo: RTL and testbench

- Synchronous byte FIFO with AXI-stream slave and master ports.
- Placed between uart_rx (upstream, feeding s_axis) and uart_tx (downstream, consuming m_axis) in the UART bridge paths.
- Absorbs bursts when the TX side is slower or busy, so received bytes are not lost while a character is being serialised.
- Provides fill level, almost-full and drop-count status for LED and seven-segment debug.

---
 rtl/uart_byte_fifo_if.sv | 24 ++
 rtl/uart_byte_fifo.sv | 71 +++++++
 tb/tb_uart_byte_fifo.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_byte_fifo_if.sv
// AXI-stream pair around the UART byte FIFO: s_axis is the ingress from uart_rx,
// m_axis is the egress towards uart_tx.
interface uart_byte_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  // A beat transfers on a rising clk edge where tvalid && tready. A source holds
  // tdata stable while tvalid=1 and tready=0, and tvalid never waits on tready.
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid
  );

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid
  );
endinterface

// File: rtl/uart_byte_fifo.sv
// First-word-fall-through byte FIFO between uart_rx and uart_tx, with fill level,
// almost-full and a saturating drop counter for debug displays.
module uart_byte_fifo #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 16,
  parameter int ALMOST_FULL    = 12,
  parameter int DROP_WHEN_FULL = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_byte_fifo_if.slave        bus,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   almost_full,
  output logic [7:0]             drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  localparam logic [AW:0] AF_LVL = ALMOST_FULL[AW:0];
  localparam bit DROP = (DROP_WHEN_FULL != 0);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  rdy_q;
  logic [7:0]            drop_q, drop_d;
  logic                  empty, full, push, pop, drop;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign bus.s_axis_tready = rdy_q && (DROP || !full);
  assign bus.m_axis_tvalid = !empty;
  assign bus.m_axis_tdata  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  assign push = bus.s_axis_tvalid && bus.s_axis_tready && !full;
  assign drop = bus.s_axis_tvalid && bus.s_axis_tready && full;
  assign pop  = !empty && bus.m_axis_tready;

  assign fill_level  = wr_ptr_q - rd_ptr_q;
  assign almost_full = (fill_level >= AF_LVL);
  assign drop_count  = drop_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    drop_d   = drop_q;
    if (push) wr_ptr_d = wr_ptr_q + ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + ONE;
    if (drop && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // rdy_q keeps s_axis_tready low until the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdy_q    <= 1'b0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdy_q    <= 1'b1;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.s_axis_tdata;
  end
endmodule

// File: tb/tb_uart_byte_fifo.sv
// Bench for uart_byte_fifo: one backpressure and one drop-mode instance driven in
// lockstep and compared every cycle with a queue-based reference model.
module tb_uart_byte_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_byte_fifo_if #(.DATA_WIDTH(DW)) bus0 ();
  uart_byte_fifo_if #(.DATA_WIDTH(DW)) bus1 ();
  logic [4:0] lvl0, lvl1;
  logic       af0, af1;
  logic [7:0] dc0, dc1;

  uart_byte_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .DROP_WHEN_FULL(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .fill_level(lvl0), .almost_full(af0), .drop_count(dc0)
  );
  uart_byte_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL(AF), .DROP_WHEN_FULL(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .fill_level(lvl1), .almost_full(af1), .drop_count(dc1)
  );

  // scoreboard / reference model: instance 0 backpressures, instance 1 drops
  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [2][$];
  bit         mdl_rdy;
  int         mdl_drop [2];

  typedef struct {
    logic       sv;
    logic [7:0] sd;
    logic       mr;
    int         lvl;
    logic       tv;
    logic [7:0] td;
    logic       tr;
  } vec_t;
  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      exp_q[k].delete();
      mdl_drop[k] = 0;
    end
    mdl_rdy = 1'b0;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic       tv, tr, afl;
      logic [7:0] td, dc;
      logic [4:0] lv;
      int         sz;
      if (k == 0) begin
        tv = bus0.m_axis_tvalid; tr = bus0.s_axis_tready; td = bus0.m_axis_tdata;
        afl = af0; dc = dc0; lv = lvl0;
      end else begin
        tv = bus1.m_axis_tvalid; tr = bus1.s_axis_tready; td = bus1.m_axis_tdata;
        afl = af1; dc = dc1; lv = lvl1;
      end
      sz = exp_q[k].size();
      chk($sformatf("tvalid%0d", k), int'(tv), int'(sz > 0));
      if (sz > 0) chk($sformatf("tdata%0d", k), int'(td), int'(exp_q[k][0]));
      chk($sformatf("level%0d", k), int'(lv), sz);
      chk($sformatf("almost_full%0d", k), int'(afl), int'(sz >= AF));
      chk($sformatf("tready%0d", k), int'(tr), int'(mdl_rdy && (k == 1 || sz < DEPTH)));
      chk($sformatf("drop_count%0d", k), int'(dc), mdl_drop[k]);
    end
  endtask

  // driver: one clock cycle with the same stimulus on both instances
  task automatic step(input logic sv, input logic [7:0] sd, input logic mr);
    bit rdy_s;
    bus0.s_axis_tvalid = sv; bus0.s_axis_tdata = sd; bus0.m_axis_tready = mr;
    bus1.s_axis_tvalid = sv; bus1.s_axis_tdata = sd; bus1.m_axis_tready = mr;
    rdy_s = mdl_rdy;
    for (int k = 0; k < 2; k++) begin
      int sz;
      bit acc, is_full;
      sz      = exp_q[k].size();
      is_full = (sz == DEPTH);
      acc     = rdy_s && (k == 1 || !is_full);
      if (sz > 0 && mr) void'(exp_q[k].pop_front());
      if (sv && acc && !is_full) exp_q[k].push_back(sd);
      if (sv && acc && is_full && mdl_drop[k] < 255) mdl_drop[k]++;
    end
    mdl_rdy = 1'b1;
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    step_inputs_idle();
    rst = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
    check_all();
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic step_inputs_idle();
    bus0.s_axis_tvalid = 1'b0; bus0.s_axis_tdata = 8'h00; bus0.m_axis_tready = 1'b0;
    bus1.s_axis_tvalid = 1'b0; bus1.s_axis_tdata = 8'h00; bus1.m_axis_tready = 1'b0;
  endtask

  task automatic drain();
    repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{1'b1, 8'h41, 1'b0, 1, 1'b1, 8'h41, 1'b1};
    vecs[1] = '{1'b1, 8'h42, 1'b0, 2, 1'b1, 8'h41, 1'b1};
    vecs[2] = '{1'b1, 8'h43, 1'b0, 3, 1'b1, 8'h41, 1'b1};
    vecs[3] = '{1'b0, 8'h00, 1'b1, 2, 1'b1, 8'h42, 1'b1};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1, 1'b1, 8'h43, 1'b1};
    vecs[5] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};
    vecs[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00, 1'b1};

    do_reset();
    chk("reset_tvalid", int'(bus0.m_axis_tvalid), 0);
    chk("reset_level", int'(lvl0), 0);

    // push 0x41..0x43 with the sink stalled, then pop them in order
    for (int i = 0; i < 7; i++) begin
      step(vecs[i].sv, vecs[i].sd, vecs[i].mr);
      chk($sformatf("vec%0d_level", i), int'(lvl0), vecs[i].lvl);
      chk($sformatf("vec%0d_tvalid", i), int'(bus0.m_axis_tvalid), int'(vecs[i].tv));
      if (vecs[i].tv) chk($sformatf("vec%0d_tdata", i), int'(bus0.m_axis_tdata), int'(vecs[i].td));
      chk($sformatf("vec%0d_tready", i), int'(bus0.s_axis_tready), int'(vecs[i].tr));
    end

    // fill to DEPTH, then offer 0x10 while full
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk($sformatf("fill%0d_af", i), int'(af0), int'(i + 1 >= AF));
    end
    chk("full_tready_bp", int'(bus0.s_axis_tready), 0);
    chk("full_tready_drop", int'(bus1.s_axis_tready), 1);
    step(1'b1, 8'h10, 1'b0);
    chk("full_hold_level", int'(lvl0), DEPTH);
    step(1'b1, 8'h10, 1'b1);
    chk("pop_no_push_level", int'(lvl0), DEPTH - 1);
    chk("tready_after_pop", int'(bus0.s_axis_tready), 1);
    step(1'b1, 8'h10, 1'b0);
    chk("accept_0x10_level", int'(lvl0), DEPTH);

    // drop-mode saturation
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      chk("drop_tready_high", int'(bus1.s_axis_tready), 1);
    end
    chk("drop_sat", int'(dc1), 255);
    chk("bp_no_drops", int'(dc0), 0);
    drain();

    // steady push+pop at level 5 with pointer wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom_range(0, 255)), 1'b1);
      chk("steady_level", int'(lvl0), 5);
    end
    drain();

    // randomized traffic with varying push/pop bias
    for (int ph = 0; ph < 3; ph++) begin
      int pp, pq;
      pp = (ph == 0) ? 80 : (ph == 1) ? 50 : 30;
      pq = (ph == 0) ? 30 : (ph == 1) ? 50 : 80;
      repeat (200) step(logic'($urandom_range(0, 99) < pp), 8'($urandom_range(0, 255)),
                        logic'($urandom_range(0, 99) < pq));
    end
    drain();

    // asynchronous reset at level 9, asserted mid-cycle
    for (int i = 0; i < 9; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    chk("pre_reset_level", int'(lvl0), 9);
    #3;
    rst = 1'b1;
    #1;
    chk("async_level0", int'(lvl0), 0);
    chk("async_level1", int'(lvl1), 0);
    chk("async_tvalid", int'(bus0.m_axis_tvalid), 0);
    chk("async_tready", int'(bus0.s_axis_tready), 0);
    chk("async_af", int'(af0), 0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    chk("post_reset_empty", int'(bus0.m_axis_tvalid), 0);
    step(1'b1, 8'hA5, 1'b0);
    chk("post_reset_head", int'(bus0.m_axis_tdata), 8'hA5);
    step(1'b0, 8'h00, 1'b1);
    chk("post_reset_drained", int'(lvl0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
